// File: rtl/mips_cpu_ifetch.sv
// Instruction-fetch reader: accepts a PC, issues one Avalon-MM word read, presents instr/pc to decode.
// Latency: 2 cycles from accept to instr_valid with no waitrequest. Backpressure: pc_ready low while busy or holding an unaccepted result.
// Optional IFETCH_STATS_EN adds saturating stat_fetches / stat_wait counters.
module mips_cpu_ifetch #(
  parameter logic [31:0] RESET_ADDR = 32'hBFC00000,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [31:0]       instr_pc,
  output logic              instr_err,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetches,
  output logic [31:0]       stat_wait
`endif
);

  typedef enum logic [1:0] {IDLE, BUS, HOLD, DISCARD} state_t;

  state_t state;
  logic   accept;

  assign pc_ready = !flush && (state == IDLE || (state == HOLD && instr_ready));
  assign accept   = pc_valid && pc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= RESET_ADDR;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (state == HOLD && flush) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end else if (accept) begin
            instr_pc <= pc_in;
            if (pc_in[1:0] == 2'b00) begin
              state       <= BUS;
              avm_read    <= 1'b1;
              avm_address <= pc_in;
              instr_valid <= 1'b0;
            end else begin
              // Misaligned PC is reported as a fetch error without touching the bus.
              state       <= HOLD;
              instr_out   <= '0;
              instr_err   <= 1'b1;
              instr_valid <= 1'b1;
            end
          end else if (state == HOLD && instr_ready) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              state       <= HOLD;
              instr_out   <= avm_readdata;
              instr_err   <= 1'b0;
              instr_valid <= 1'b1;
            end
          end else if (flush) begin
            // The read cannot be withdrawn mid-wait; finish it and drop the data.
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetches <= '0;
      stat_wait    <= '0;
    end else begin
      if (state == BUS && !avm_waitrequest && !flush && stat_fetches != 32'hFFFFFFFF)
        stat_fetches <= stat_fetches + 32'd1;
      if (avm_read && avm_waitrequest && stat_wait != 32'hFFFFFFFF)
        stat_wait <= stat_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Bench for mips_cpu_ifetch: directed scenarios with literal expectations, then random traffic
// compared against a transaction-level reference model.
module tb_mips_cpu_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        instr_valid;
  logic        instr_ready;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetches;
  logic [31:0] stat_wait;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cpu_ifetch #(.RESET_ADDR(32'hBFC00000), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_err(instr_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef IFETCH_STATS_EN
    , .stat_fetches(stat_fetches), .stat_wait(stat_wait)
`endif
  );

  // Apply inputs just after an edge, sample pc_ready before the next edge, return 1ns after it.
  task automatic cyc(input logic pv, input logic [31:0] pa, input logic fl, input logic wr,
                     input logic ir, input logic [31:0] rd, output logic pr);
    pc_valid = pv; pc_in = pa; flush = fl; avm_waitrequest = wr; instr_ready = ir; avm_readdata = rd;
    #1 pr = pc_ready;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_valid = 1'b0; pc_in = '0; flush = 1'b0;
    avm_waitrequest = 1'b0; instr_ready = 1'b0; avm_readdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL reset_read got %b want 0", avm_read); end
    n_cmp++; if (avm_address !== 32'hBFC00000) begin n_bad++; $display("FAIL reset_addr got %h want bfc00000", avm_address); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_cmp++; if ({instr_out, instr_pc, instr_err} !== 65'd0) begin n_bad++; $display("FAIL reset_instr got %h/%h/%b want 0", instr_out, instr_pc, instr_err); end
    #1;
    n_cmp++; if (pc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_pc_ready got %b want 1", pc_ready); end
`ifdef IFETCH_STATS_EN
    n_cmp++; if ({stat_fetches, stat_wait} !== 64'd0) begin n_bad++; $display("FAIL reset_stats got %h/%h want 0", stat_fetches, stat_wait); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_basic_fetch();
    logic pr;
    cyc(1'b1, 32'hBFC00000, 1'b0, 1'b0, 1'b0, 32'h0, pr);
    n_cmp++; if (pr !== 1'b1) begin n_bad++; $display("FAIL basic_accept got %b want 1", pr); end
    n_cmp++; if ({avm_read, avm_address, instr_valid} !== {1'b1, 32'hBFC00000, 1'b0}) begin n_bad++; $display("FAIL basic_bus got %b/%h/%b want 1/bfc00000/0", avm_read, avm_address, instr_valid); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h24020005, pr);
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL basic_read_drop got %b want 0", avm_read); end
    n_cmp++; if ({instr_valid, instr_out, instr_pc, instr_err} !== {1'b1, 32'h24020005, 32'hBFC00000, 1'b0}) begin n_bad++; $display("FAIL basic_result got %b/%h/%h/%b want 1/24020005/bfc00000/0", instr_valid, instr_out, instr_pc, instr_err); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, pr);
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume got %b want 0", instr_valid); end
  endtask

  task automatic test_waitrequest();
    logic pr;
`ifdef IFETCH_STATS_EN
    logic [31:0] w0, f0;
    w0 = stat_wait; f0 = stat_fetches;
`endif
    cyc(1'b1, 32'hBFC00004, 1'b0, 1'b1, 1'b0, 32'h0, pr);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD0000 + i, pr);
      n_cmp++; if ({avm_read, avm_address, instr_valid} !== {1'b1, 32'hBFC00004, 1'b0}) begin n_bad++; $display("FAIL wait_stable[%0d] got %b/%h/%b want 1/bfc00004/0", i, avm_read, avm_address, instr_valid); end
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8C220000, pr);
    n_cmp++; if ({avm_read, instr_valid, instr_out, instr_pc} !== {1'b0, 1'b1, 32'h8C220000, 32'hBFC00004}) begin n_bad++; $display("FAIL wait_result got %b/%b/%h/%h want 0/1/8c220000/bfc00004", avm_read, instr_valid, instr_out, instr_pc); end
`ifdef IFETCH_STATS_EN
    n_cmp++; if (stat_wait - w0 !== 32'd3) begin n_bad++; $display("FAIL wait_stat_wait got %0d want 3", stat_wait - w0); end
    n_cmp++; if (stat_fetches - f0 !== 32'd1) begin n_bad++; $display("FAIL wait_stat_fetches got %0d want 1", stat_fetches - f0); end
`endif
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, pr);
  endtask

  task automatic test_hold_backpressure();
    logic pr;
    cyc(1'b1, 32'hBFC00010, 1'b0, 1'b0, 1'b0, 32'h0, pr);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3C1DA000, pr);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hBFC00008, 1'b0, 1'b0, 1'b0, $urandom, pr);
      n_cmp++; if (pr !== 1'b0) begin n_bad++; $display("FAIL hold_pc_ready[%0d] got %b want 0", i, pr); end
      n_cmp++; if ({instr_valid, instr_out, instr_pc, avm_read} !== {1'b1, 32'h3C1DA000, 32'hBFC00010, 1'b0}) begin n_bad++; $display("FAIL hold_stable[%0d] got %b/%h/%h/%b want 1/3c1da000/bfc00010/0", i, instr_valid, instr_out, instr_pc, avm_read); end
    end
    cyc(1'b1, 32'hBFC00008, 1'b0, 1'b0, 1'b1, 32'h0, pr);
    n_cmp++; if (pr !== 1'b1) begin n_bad++; $display("FAIL b2b_pc_ready got %b want 1", pr); end
    n_cmp++; if ({avm_read, avm_address, instr_valid} !== {1'b1, 32'hBFC00008, 1'b0}) begin n_bad++; $display("FAIL b2b_issue got %b/%h/%b want 1/bfc00008/0", avm_read, avm_address, instr_valid); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00000000, pr);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, pr);
  endtask

  task automatic test_flush_discard();
    logic pr;
    logic saw_valid;
`ifdef IFETCH_STATS_EN
    logic [31:0] f0;
    f0 = stat_fetches;
`endif
    saw_valid = 1'b0;
    cyc(1'b1, 32'hBFC0000C, 1'b0, 1'b1, 1'b0, 32'h0, pr);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, (i == 1), 1'b1, 1'b1, $urandom, pr);
      saw_valid |= instr_valid;
      n_cmp++; if ({avm_read, avm_address} !== {1'b1, 32'hBFC0000C}) begin n_bad++; $display("FAIL flush_read_held[%0d] got %b/%h want 1/bfc0000c", i, avm_read, avm_address); end
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, pr);
    saw_valid |= instr_valid;
    n_cmp++; if (avm_read !== 1'b0) begin n_bad++; $display("FAIL flush_read_end got %b want 0", avm_read); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, pr);
    saw_valid |= instr_valid;
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_valid got %b want 0", saw_valid); end
    n_cmp++; if (pr !== 1'b1) begin n_bad++; $display("FAIL flush_idle_after got pc_ready %b want 1", pr); end
`ifdef IFETCH_STATS_EN
    n_cmp++; if (stat_fetches !== f0) begin n_bad++; $display("FAIL flush_stat_fetches got %0d want %0d", stat_fetches, f0); end
`endif
  endtask

  task automatic test_misaligned();
    logic pr;
    cyc(1'b1, 32'hBFC00002, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, pr);
    n_cmp++; if ({avm_read, avm_address} !== {1'b0, 32'hBFC0000C}) begin n_bad++; $display("FAIL misal_no_bus got %b/%h want 0/bfc0000c", avm_read, avm_address); end
    n_cmp++; if ({instr_valid, instr_err, instr_out, instr_pc} !== {1'b1, 1'b1, 32'h0, 32'hBFC00002}) begin n_bad++; $display("FAIL misal_result got %b/%b/%h/%h want 1/1/0/bfc00002", instr_valid, instr_err, instr_out, instr_pc); end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, pr);
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL misal_consume got %b want 0", instr_valid); end
  endtask

  // Reference model: tracks whether a read is outstanding (and whether it is doomed), and the
  // instruction currently offered to decode, updated from the protocol rules each cycle.
  task automatic test_random();
    logic        m_rd, m_drop, m_vld, m_err;
    logic [31:0] m_addr, m_pc, m_out, m_fetch, m_wait;
    logic        n_rd, n_drop, n_vld, n_err;
    logic [31:0] n_addr, n_pc, n_out;
    logic        pv, fl, wr, ir, pr, exp_ready, acc;
    logic [31:0] pa, rd;
    do_reset();
    m_rd = 0; m_drop = 0; m_vld = 0; m_err = 0;
    m_addr = 32'hBFC00000; m_pc = 0; m_out = 0; m_fetch = 0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      pv = ($urandom_range(0, 1) == 1);
      pa = 32'hBFC00000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 7) == 0) pa[1:0] = 2'($urandom_range(1, 3));
      fl = ($urandom_range(0, 11) == 0);
      wr = ($urandom_range(0, 9) < 4);
      ir = ($urandom_range(0, 9) < 6);
      rd = $urandom;
      exp_ready = !fl && ((!m_rd && !m_vld) || (m_vld && ir));
      acc = pv && exp_ready;
      {n_rd, n_drop, n_vld, n_err, n_addr, n_pc, n_out} = {m_rd, m_drop, m_vld, m_err, m_addr, m_pc, m_out};
      if (m_rd) begin
        if (wr) begin
          m_wait++;
          if (fl) n_drop = 1;
        end else begin
          n_rd = 0;
          if (!m_drop && !fl) begin n_vld = 1; n_out = rd; n_err = 0; m_fetch++; end
        end
      end else if (m_vld && fl) begin
        n_vld = 0;
      end else if (acc) begin
        n_pc = pa;
        if (pa[1:0] == 2'b00) begin n_rd = 1; n_drop = 0; n_addr = pa; n_vld = 0; end
        else begin n_vld = 1; n_out = 0; n_err = 1; end
      end else if (m_vld && ir) begin
        n_vld = 0;
      end
      cyc(pv, pa, fl, wr, ir, rd, pr);
      {m_rd, m_drop, m_vld, m_err, m_addr, m_pc, m_out} = {n_rd, n_drop, n_vld, n_err, n_addr, n_pc, n_out};
      n_cmp++; if (pr !== exp_ready) begin n_bad++; $display("FAIL rand_pc_ready c=%0d got %b want %b", c, pr, exp_ready); end
      n_cmp++; if ({avm_read, avm_address, instr_valid} !== {m_rd, m_addr, m_vld}) begin n_bad++; $display("FAIL rand_bus c=%0d got %b/%h/%b want %b/%h/%b", c, avm_read, avm_address, instr_valid, m_rd, m_addr, m_vld); end
      if (m_vld) begin
        n_cmp++; if ({instr_out, instr_pc, instr_err} !== {m_out, m_pc, m_err}) begin n_bad++; $display("FAIL rand_instr c=%0d got %h/%h/%b want %h/%h/%b", c, instr_out, instr_pc, instr_err, m_out, m_pc, m_err); end
      end
`ifdef IFETCH_STATS_EN
      n_cmp++; if ({stat_fetches, stat_wait} !== {m_fetch, m_wait}) begin n_bad++; $display("FAIL rand_stats c=%0d got %0d/%0d want %0d/%0d", c, stat_fetches, stat_wait, m_fetch, m_wait); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_waitrequest();
    test_hold_backpressure();
    test_flush_discard();
    test_misaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
